// File: rtl/dmactr_mc.sv
// dmactr_mc: multi-channel DMA controller with round-robin arbitration.
// Pending channels are served one complete transfer at a time; the bus is
// released for one cycle after every BURST words moved.
module dmactr_mc #(
    parameter int unsigned CH     = 2,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned BURST  = 4
) (
    input  logic                 clk,
    input  logic                 reset_,
    output logic [ADDR_W-1:0]    addr,
    output logic [DATA_W-1:0]    odata,
    input  logic [DATA_W-1:0]    idata,
    output logic                 rw_,
    output logic                 breq_,
    input  logic                 bgrt_,
    input  logic [CH*ADDR_W-1:0] dsaddr,
    input  logic [CH*ADDR_W-1:0] ddaddr,
    input  logic [CH*LEN_W-1:0]  dlen,
    input  logic [CH-1:0]        dsinc,
    input  logic [CH-1:0]        ddinc,
    input  logic [CH-1:0]        dreq_,
    output logic [CH-1:0]        eop_,
    output logic [CH-1:0]        busy
);

    localparam int unsigned PW = (CH > 1) ? $clog2(CH) : 1;
    localparam int unsigned BW = $clog2(BURST + 1);

    typedef enum logic [2:0] {
        IDLE, READ, WRITE, RELEASE, REREQ, DONE
    } state_t;

    state_t              state, state_n;
    logic [PW-1:0]       ptr, ptr_n, win, win_n, pick;
    logic [PW:0]         slot;
    logic                found;
    logic [ADDR_W-1:0]   sa, sa_n, da, da_n, addr_n;
    logic [LEN_W-1:0]    cnt, cnt_n;
    logic [BW-1:0]       beat, beat_n;
    logic                sinc, sinc_n, dinc, dinc_n;
    logic [DATA_W-1:0]   odata_n;
    logic                rw_n, breq_n;
    logic [CH-1:0]       eop_n, busy_n;

    // State, working registers and registered bus outputs
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state <= IDLE;
            ptr   <= '0;
            win   <= '0;
            sa    <= '0;
            da    <= '0;
            cnt   <= '0;
            beat  <= '0;
            sinc  <= 1'b0;
            dinc  <= 1'b0;
            addr  <= '0;
            odata <= '0;
            rw_   <= 1'b1;
            breq_ <= 1'b1;
            eop_  <= '1;
            busy  <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            win   <= win_n;
            sa    <= sa_n;
            da    <= da_n;
            cnt   <= cnt_n;
            beat  <= beat_n;
            sinc  <= sinc_n;
            dinc  <= dinc_n;
            addr  <= addr_n;
            odata <= odata_n;
            rw_   <= rw_n;
            breq_ <= breq_n;
            eop_  <= eop_n;
            busy  <= busy_n;
        end
    end

    // Round-robin pick, next state and next register/output values
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        win_n   = win;
        sa_n    = sa;
        da_n    = da;
        cnt_n   = cnt;
        beat_n  = beat;
        sinc_n  = sinc;
        dinc_n  = dinc;
        addr_n  = addr;
        odata_n = odata;
        rw_n    = rw_;
        breq_n  = breq_;
        eop_n   = '1;
        busy_n  = busy;
        found   = 1'b0;
        pick    = '0;
        slot    = '0;

        // Scan starting at the pointer, wrapping at CH; first low request wins
        for (int unsigned i = 0; i < CH; i++) begin
            slot = {1'b0, ptr} + (PW+1)'(i);
            if (slot >= (PW+1)'(CH))
                slot = slot - (PW+1)'(CH);
            if (!found && !dreq_[slot[PW-1:0]]) begin
                found = 1'b1;
                pick  = slot[PW-1:0];
            end
        end

        case (state)
            IDLE: begin
                if (found) begin
                    win_n  = pick;
                    beat_n = '0;
                    busy_n = '0;
                    // Increment modes are captured with the addresses so the
                    // whole transfer descriptor is fixed for its duration.
                    for (int unsigned k = 0; k < CH; k++) begin
                        if (pick == PW'(k)) begin
                            sa_n      = dsaddr[k*ADDR_W +: ADDR_W];
                            da_n      = ddaddr[k*ADDR_W +: ADDR_W];
                            cnt_n     = dlen[k*LEN_W +: LEN_W];
                            sinc_n    = dsinc[k];
                            dinc_n    = ddinc[k];
                            busy_n[k] = 1'b1;
                        end
                    end
                    if (cnt_n == '0) begin
                        state_n = DONE;
                    end else begin
                        breq_n  = 1'b0;
                        state_n = READ;
                    end
                end
            end
            READ: begin
                rw_n = 1'b1;
                if (!bgrt_) begin
                    addr_n  = sa;
                    state_n = WRITE;
                end
            end
            WRITE: begin
                addr_n  = da;
                rw_n    = 1'b0;
                odata_n = idata;
                cnt_n   = cnt - LEN_W'(1);
                beat_n  = beat + BW'(1);
                if (sinc)
                    sa_n = sa + ADDR_W'(1);
                if (dinc)
                    da_n = da + ADDR_W'(1);
                if (cnt == LEN_W'(1))
                    state_n = DONE;
                else if (beat + BW'(1) == BW'(BURST))
                    state_n = RELEASE;
                else
                    state_n = READ;
            end
            RELEASE: begin
                breq_n  = 1'b1;
                rw_n    = 1'b1;
                beat_n  = '0;
                state_n = REREQ;
            end
            REREQ: begin
                breq_n  = 1'b0;
                state_n = READ;
            end
            DONE: begin
                for (int unsigned k = 0; k < CH; k++) begin
                    if (win == PW'(k))
                        eop_n[k] = 1'b0;
                end
                breq_n  = 1'b1;
                rw_n    = 1'b1;
                busy_n  = '0;
                ptr_n   = (win == PW'(CH - 1)) ? '0 : win + PW'(1);
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
